digit_serial_adder: RTL and testbench
=====================================

DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (>=2).
REQ-002 SHALL have parameter DIGIT, default 1, bits added per clock; WIDTH mod DIGIT SHALL be 0 (elaboration error otherwise).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  request; accepted only in IDLE or DONE.
REQ-006 a  input  WIDTH  operand A, sampled on accepted start.
REQ-007 b  input  WIDTH  operand B, sampled on accepted start.
REQ-008 ci  input  1  carry-in, sampled on accepted start.
REQ-009 s  output  WIDTH  registered sum.
REQ-010 co  output  1  registered carry-out.
REQ-011 ovf  output  1  registered signed overflow (carry into MSB XOR carry out of MSB).
REQ-012 busy  output  1  high while computing.
REQ-013 done  output  1  one-cycle result-valid pulse.

Function
REQ-014 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; N = WIDTH/DIGIT.
REQ-015 On accepted start: load a, b into shift registers, carry register <= ci, digit counter <= 0, go BUSY.
REQ-016 Each BUSY cycle SHALL add the low DIGIT bits of A, B plus carry register, shift sum digit into result register from MSB side, update carry, shift A/B right by DIGIT.
REQ-017 After exactly N BUSY cycles SHALL go DONE; s, co, ovf SHALL update on the edge entering DONE.
REQ-018 Latency: start sampled at edge t; done=1 during the cycle after edge t+N; busy=1 during cycles after edges t..t+N-1.
REQ-019 done SHALL be high exactly one cycle per accepted start.
REQ-020 s, co, ovf SHALL hold their values until the next DONE entry or reset.
REQ-021 start while BUSY SHALL be ignored, with no effect on operands or count.
REQ-022 start in DONE SHALL be accepted (back-to-back); next state BUSY, no IDLE cycle.
REQ-023 Sum SHALL wrap modulo 2^WIDTH; co is the true bit WIDTH of a+b+ci.
REQ-024 DIGIT = WIDTH SHALL be legal: N=1, single BUSY cycle.

Reset
REQ-025 rst high SHALL immediately force IDLE, s=0, co=0, ovf=0, busy=0, done=0, clear counter, carry and shift registers.
REQ-026 Reset mid-BUSY SHALL abort; no done pulse SHALL follow for the aborted operation.
REQ-027 First start SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro DSA_SUB_EN defined: SHALL add input sub (1 bit, sampled with start); sub=1 computes a + ~b + 1 (ci ignored), co = no-borrow flag, ovf = signed subtraction overflow.
REQ-029 DSA_SUB_EN undefined: no sub port; add only, per REQ-015..REQ-023.

Structure
REQ-030 Package dsa_pkg SHALL hold the FSM state type (IDLE, BUSY, DONE) and counter-width function clog2(N).
REQ-031 SHALL instantiate one sub-module digit_adder (parameter DIGIT; inputs x, y, cin; outputs sum, cout, cmsb = carry into top bit), purely combinational.

Verification
REQ-032 WIDTH=8, DIGIT=1: a=8'h3C, b=8'h05, ci=0 -> done 9 edges after start, s=8'h41, co=0, ovf=0.
REQ-033 WIDTH=8, DIGIT=2: a=8'hFF, b=8'h01, ci=1 -> after 4 BUSY cycles s=8'h01, co=1, ovf=0; a=8'h7F, b=8'h01, ci=0 -> s=8'h80, co=0, ovf=1.
REQ-034 Start pulsed every cycle during BUSY -> ignored; exactly one done; result equals first operands.
REQ-035 Back-to-back: new start in DONE cycle with a=1, b=2 -> busy next cycle, no IDLE, second done gives s=3.
REQ-036 rst asserted in 3rd BUSY cycle -> outputs 0 asynchronously, no done for 20 cycles, next start computes correctly.
REQ-037 DSA_SUB_EN, WIDTH=8: sub=1, a=8'h05, b=8'h07 -> s=8'hFE, co=0, ovf=0; a=8'h80, b=8'h01 -> s=8'h7F, co=1, ovf=1.

Source files
------------

// File: rtl/dsa_pkg.sv
// Shared types and helpers for the digit-serial adder.
// Holds the controller state encoding and the counter-width helper.
package dsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2; returns 0 for n <= 1.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // A digit counter needs at least one bit even when there is a single digit.
  function automatic int cnt_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/digit_adder.sv
// Combinational DIGIT-bit adder slice used by the serial datapath.
// cmsb is the carry into the top bit of the slice, which the top level
// uses on the final digit to form the signed overflow flag.
module digit_adder #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] full;

  assign full = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
  assign sum  = full[DIGIT-1:0];
  assign cout = full[DIGIT];
  // The top sum bit is x ^ y ^ carry-in, so the carry into it is recovered by XOR.
  assign cmsb = full[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock.
// Optional build macro DSA_SUB_EN adds a 'sub' input selecting a - b
// (computed as a + ~b + 1, carry-out is the no-borrow flag).
module digit_serial_adder
  import dsa_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef DSA_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("digit_serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last;
  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic             dcmsb;

  // A start is honoured in IDLE and in DONE (back-to-back), never mid-computation.
  assign accept = start && (state != BUSY);
  assign last   = (state == BUSY) && (cnt == LAST);
  assign busy   = (state == BUSY);
  assign done   = (state == DONE);

`ifdef DSA_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub ? 1'b1 : ci;
`else
  assign b_load = b;
  assign c_load = ci;
`endif

  digit_adder #(
    .DIGIT(DIGIT)
  ) u_digit_adder (
    .x    (a_sh[DIGIT-1:0]),
    .y    (b_sh[DIGIT-1:0]),
    .cin  (carry),
    .sum  (dsum),
    .cout (dcout),
    .cmsb (dcmsb)
  );

  // Result digits enter from the MSB side so after N shifts digit 0 sits at the bottom.
  if (DIGIT == WIDTH) begin : g_single_digit
    assign res_next = dsum;
  end else begin : g_multi_digit
    assign res_next = {dsum, res_sh[WIDTH-1:DIGIT]};
  end

  // State register; reset forces IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> BUSY -> DONE -> IDLE, with DONE able to restart directly.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = BUSY;
      BUSY:    if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, add/shift one digit per BUSY cycle, publish on the last digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      s      <= '0;
      co     <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b_load;
      res_sh <= '0;
      carry  <= c_load;
      cnt    <= '0;
    end else if (state == BUSY) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      res_sh <= res_next;
      carry  <= dcout;
      cnt    <= cnt + 1'b1;
      if (last) begin
        s   <= res_next;
        co  <= dcout;
        ovf <= dcmsb ^ dcout;
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder.
// Three instances (DIGIT = 1, 2, 8 at WIDTH = 8) share clock and reset; expected
// results are pushed to a per-instance queue at launch and popped on each done pulse.
module tb_digit_serial_adder;

  localparam int W = 8;
  localparam int NI = 3;
  localparam int DIGITS [NI] = '{1, 2, 8};

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
  } res_t;

  logic         clk;
  logic         rst;
  logic         start_v [NI];
  logic [W-1:0] a_v     [NI];
  logic [W-1:0] b_v     [NI];
  logic         ci_v    [NI];
`ifdef DSA_SUB_EN
  logic         sub_v   [NI];
`endif
  logic [W-1:0] s_v     [NI];
  logic         co_v    [NI];
  logic         ovf_v   [NI];
  logic         busy_v  [NI];
  logic         done_v  [NI];

  res_t exp_q [NI][$];
  res_t last_exp [NI];

  int tests;
  int failures;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    digit_serial_adder #(
      .WIDTH(W),
      .DIGIT(DIGITS[g])
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start_v[g]),
      .a     (a_v[g]),
      .b     (b_v[g]),
      .ci    (ci_v[g]),
`ifdef DSA_SUB_EN
      .sub   (sub_v[g]),
`endif
      .s     (s_v[g]),
      .co    (co_v[g]),
      .ovf   (ovf_v[g]),
      .busy  (busy_v[g]),
      .done  (done_v[g])
    );
  end

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain integer add with a wider sum, overflow from operand/result signs.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic ci, input logic sub);
    res_t         r;
    logic [W-1:0] bb;
    logic         cc;
    logic [W:0]   full;
    bb    = sub ? ~b : b;
    cc    = sub ? 1'b1 : ci;
    full  = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cc};
    r.s   = full[W-1:0];
    r.co  = full[W];
    r.ovf = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one operation on instance i at the current negedge and record its expected result.
  task automatic applyStimulus(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic ci, input logic sub);
    a_v[i]     = a;
    b_v[i]     = b;
    ci_v[i]    = ci;
`ifdef DSA_SUB_EN
    sub_v[i]   = sub;
`endif
    start_v[i] = 1'b1;
    exp_q[i].push_back(model(a, b, ci, sub));
    @(posedge clk);
    #1 start_v[i] = 1'b0;
  endtask

  // Follow an accepted operation: N busy cycles, then exactly one done cycle.
  // With jam set, start is held high with junk operands throughout BUSY.
  task automatic trackOp(input int i, input bit jam);
    int n;
    n = W / DIGITS[i];
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checkOutput($sformatf("d%0d_busy_c%0d", i, k), busy_v[i], 1);
      checkOutput($sformatf("d%0d_nodone_c%0d", i, k), done_v[i], 0);
      if (jam) begin
        start_v[i] = 1'b1;
        a_v[i]     = 8'($urandom);
        b_v[i]     = 8'($urandom);
        ci_v[i]    = 1'($urandom);
      end
    end
    @(negedge clk);
    start_v[i] = 1'b0;
    checkOutput($sformatf("d%0d_done", i), done_v[i], 1);
    checkOutput($sformatf("d%0d_busy_off", i), busy_v[i], 0);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    res_t e;
    for (int i = 0; i < NI; i++) begin
      if (done_v[i] === 1'b1) begin
        if (exp_q[i].size() == 0) begin
          checkOutput($sformatf("d%0d_spurious_done", i), 1, 0);
        end else begin
          e = exp_q[i].pop_front();
          checkOutput($sformatf("d%0d_sum", i), s_v[i], e.s);
          checkOutput($sformatf("d%0d_co", i), co_v[i], e.co);
          checkOutput($sformatf("d%0d_ovf", i), ovf_v[i], e.ovf);
          last_exp[i] = e;
        end
      end
    end
  end

  initial begin
    tests    = 0;
    failures = 0;
    rst      = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start_v[i]  = 1'b0;
      a_v[i]      = '0;
      b_v[i]      = '0;
      ci_v[i]     = 1'b0;
`ifdef DSA_SUB_EN
      sub_v[i]    = 1'b0;
`endif
      last_exp[i] = '0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("d%0d_rst_s", i), s_v[i], 0);
      checkOutput($sformatf("d%0d_rst_co", i), co_v[i], 0);
      checkOutput($sformatf("d%0d_rst_ovf", i), ovf_v[i], 0);
      checkOutput($sformatf("d%0d_rst_busy", i), busy_v[i], 0);
      checkOutput($sformatf("d%0d_rst_done", i), done_v[i], 0);
    end

    // First start taken on the first edge after reset release
    rst = 1'b0;
    applyStimulus(0, 8'h3C, 8'h05, 1'b0, 1'b0);
    trackOp(0, 1'b0);

    // Two-bit digits: carry chain through all digits, then signed overflow
    @(negedge clk);
    applyStimulus(1, 8'hFF, 8'h01, 1'b1, 1'b0);
    trackOp(1, 1'b0);
    @(negedge clk);
    applyStimulus(1, 8'h7F, 8'h01, 1'b0, 1'b0);
    trackOp(1, 1'b0);

    // Single-digit configuration (N = 1)
    @(negedge clk);
    applyStimulus(2, 8'h7F, 8'h7F, 1'b1, 1'b0);
    trackOp(2, 1'b0);
    @(negedge clk);
    applyStimulus(2, 8'hFF, 8'hFF, 1'b1, 1'b0);
    trackOp(2, 1'b0);

    // Start hammered during BUSY must be ignored
    @(negedge clk);
    applyStimulus(1, 8'h12, 8'h34, 1'b0, 1'b0);
    trackOp(1, 1'b1);
    repeat (3) begin
      @(negedge clk);
      checkOutput("d1_jam_no_extra_done", done_v[1], 0);
    end

    // Back-to-back: restart in the DONE cycle, busy must follow with no IDLE gap
    @(negedge clk);
    applyStimulus(1, 8'h20, 8'h30, 1'b1, 1'b0);
    trackOp(1, 1'b0);
    applyStimulus(1, 8'h01, 8'h02, 1'b0, 1'b0);
    trackOp(1, 1'b0);

    // Reset in the 3rd BUSY cycle aborts the operation
    @(negedge clk);
    applyStimulus(0, 8'hF0, 8'h20, 1'b1, 1'b0);
    trackOp(0, 1'b0);
    @(negedge clk);
    applyStimulus(0, 8'hAA, 8'h55, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("d0_abort_s", s_v[0], 0);
    checkOutput("d0_abort_co", co_v[0], 0);
    checkOutput("d0_abort_busy", busy_v[0], 0);
    checkOutput("d0_abort_done", done_v[0], 0);
    exp_q[0].delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      checkOutput("d0_abort_quiet", done_v[0], 0);
    end
    applyStimulus(0, 8'h50, 8'h40, 1'b0, 1'b0);
    trackOp(0, 1'b0);

`ifdef DSA_SUB_EN
    // Subtraction: no-borrow flag and signed subtraction overflow
    @(negedge clk);
    applyStimulus(0, 8'h05, 8'h07, 1'b1, 1'b1);
    trackOp(0, 1'b0);
    applyStimulus(0, 8'h80, 8'h01, 1'b0, 1'b1);
    trackOp(0, 1'b0);
`endif

    // Random operations on every instance, chained back-to-back
    for (int i = 0; i < NI; i++) begin
      @(negedge clk);
      for (int k = 0; k < 6; k++) begin
`ifdef DSA_SUB_EN
        applyStimulus(i, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
`else
        applyStimulus(i, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
`endif
        trackOp(i, 1'b0);
      end
    end

    // Results hold after DONE and nothing is left outstanding
    repeat (4) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      checkOutput($sformatf("d%0d_drained", i), exp_q[i].size(), 0);
      checkOutput($sformatf("d%0d_hold_s", i), s_v[i], last_exp[i].s);
      checkOutput($sformatf("d%0d_hold_co", i), co_v[i], last_exp[i].co);
      checkOutput($sformatf("d%0d_hold_ovf", i), ovf_v[i], last_exp[i].ovf);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
